// File: rtl/multicore_pkg.sv
// Shared types for the external memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicore_pkg;

    localparam int LINE_WORDS = 4;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_IF,
        OWNER_MA
    } arb_owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_DRAIN,
        ARB_DONE
    } arb_state_e;

endpackage

// File: rtl/mem_arb_select.sv
// Winner pick between fetch and data requesters, with an MA streak counter that forces fetch progress.
// Latency: grants are combinational in the arbitrate cycle; the streak updates on the next edge.
// Backpressure: requesters hold req until their grant; no grant is issued unless arbitrate is high.
module mem_arb_select #(
    parameter int MAX_MA_STREAK = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic ma_req,
    input  logic arbitrate,
    output logic gnt_if,
    output logic gnt_ma
);

    localparam int SW = $clog2(MAX_MA_STREAK + 1);

    logic [SW-1:0] streak;
    logic          force_if;
    logic          ma_win;
    logic          if_win;

    // The data side holds the older instruction, so it wins unless fetch has waited too long.
    assign force_if = if_req && (streak == SW'(MAX_MA_STREAK));
    assign ma_win   = ma_req && !force_if;
    assign if_win   = if_req && !ma_win;
    assign gnt_ma   = arbitrate && ma_win;
    assign gnt_if   = arbitrate && if_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (arbitrate) begin
            if (!if_req || if_win) begin
                streak <= '0;
            end else if (ma_win && (streak != SW'(MAX_MA_STREAK))) begin
                streak <= streak + SW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch line bursts and data line reads / word writes.
// Latency: grant to first command 1 cycle; each response forwarded 1 cycle after i_mem_rvalid; done 1 cycle after the last beat.
// Backpressure: o_mem_req holds address/data until i_mem_ready; requesters hold req until their one-cycle grant.
module mem_port_arbiter #(
    parameter int LINE_WORDS    = multicore_pkg::LINE_WORDS,
    parameter int MAX_MA_STREAK = 3
) (
    input  logic        i_aclk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_abort,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    output logic        o_if_done,
    input  logic        i_ma_req,
    input  logic        i_ma_we,
    input  logic [31:0] i_ma_addr,
    input  logic [31:0] i_ma_wdata,
    output logic        o_ma_gnt,
    output logic        o_ma_rvalid,
    output logic [31:0] o_ma_rdata,
    output logic        o_ma_done,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    import multicore_pkg::*;

    localparam int          CW        = $clog2(LINE_WORDS + 1);
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

    arb_state_e    state;
    arb_state_e    state_nxt;
    arb_owner_e    owner;
    logic [31:0]   base_addr;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic          aborted;
    logic [CW-1:0] issued;
    logic [CW-1:0] rcvd;
    logic [CW-1:0] issued_nxt;
    logic [CW-1:0] rcvd_nxt;
    logic [CW-1:0] beat_total;
    logic          arb_en;
    logic          gnt_if;
    logic          gnt_ma;
    logic          mem_acc;
    logic          rsp_ok;
    logic          abort_now;
    logic          if_fwd;
    logic          ma_fwd;

    mem_arb_select #(
        .MAX_MA_STREAK(MAX_MA_STREAK)
    ) u_sel (
        .clk       (i_aclk),
        .reset     (i_reset),
        .if_req    (i_if_req),
        .ma_req    (i_ma_req),
        .arbitrate (arb_en),
        .gnt_if    (gnt_if),
        .gnt_ma    (gnt_ma)
    );

    assign arb_en   = (state == ARB_IDLE) && !i_reset;
    assign o_if_gnt = gnt_if;
    assign o_ma_gnt = gnt_ma;

    assign beat_total = we_q ? CW'(1) : CW'(LINE_WORDS);
    assign o_mem_req  = (state == ARB_ISSUE);
    assign mem_acc    = o_mem_req && i_mem_ready;
    // A response with nothing outstanding is a protocol error and is dropped.
    assign rsp_ok     = i_mem_rvalid && (rcvd < issued);
    assign abort_now  = i_if_abort && (owner == OWNER_IF) &&
                        ((state == ARB_ISSUE) || (state == ARB_DRAIN));
    assign issued_nxt = issued + CW'(mem_acc);
    assign rcvd_nxt   = rcvd + CW'(rsp_ok);
    assign if_fwd     = rsp_ok && (owner == OWNER_IF) && !(aborted || abort_now);
    assign ma_fwd     = rsp_ok && (owner == OWNER_MA);

    assign o_mem_addr  = o_mem_req ? (base_addr + (32'(issued) << 2)) : '0;
    assign o_mem_we    = o_mem_req && we_q;
    assign o_mem_wdata = o_mem_req ? wdata_q : '0;
    assign o_busy      = (state != ARB_IDLE);
    assign o_if_done   = (state == ARB_DONE) && (owner == OWNER_IF);
    assign o_ma_done   = (state == ARB_DONE) && (owner == OWNER_MA);

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (gnt_if || gnt_ma) state_nxt = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                // A beat accepted in the abort cycle still counts and must be drained.
                if (abort_now) begin
                    state_nxt = (issued_nxt == rcvd_nxt) ? ARB_IDLE : ARB_DRAIN;
                end else if (mem_acc && (issued_nxt == beat_total)) begin
                    state_nxt = we_q ? ARB_DONE : ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (abort_now) begin
                    state_nxt = (rcvd_nxt == issued) ? ARB_IDLE : ARB_DRAIN;
                end else if (rcvd == issued) begin
                    state_nxt = aborted ? ARB_IDLE : ARB_DONE;
                end
            end
            ARB_DONE: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            state       <= ARB_IDLE;
            owner       <= OWNER_NONE;
            base_addr   <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            aborted     <= 1'b0;
            issued      <= '0;
            rcvd        <= '0;
            o_if_rvalid <= 1'b0;
            o_if_rdata  <= '0;
            o_ma_rvalid <= 1'b0;
            o_ma_rdata  <= '0;
        end else begin
            state       <= state_nxt;
            o_if_rvalid <= if_fwd;
            o_ma_rvalid <= ma_fwd;
            if (if_fwd) o_if_rdata <= i_mem_rdata;
            if (ma_fwd) o_ma_rdata <= i_mem_rdata;
            if (gnt_if || gnt_ma) begin
                owner     <= gnt_ma ? OWNER_MA : OWNER_IF;
                base_addr <= gnt_ma ? i_ma_addr : (i_if_addr & LINE_MASK);
                we_q      <= gnt_ma && i_ma_we;
                wdata_q   <= gnt_ma ? i_ma_wdata : '0;
                aborted   <= 1'b0;
                issued    <= '0;
                rcvd      <= '0;
            end else begin
                issued <= issued_nxt;
                rcvd   <= rcvd_nxt;
                if (abort_now) aborted <= 1'b1;
                if (state_nxt == ARB_IDLE) begin
                    owner   <= OWNER_NONE;
                    aborted <= 1'b0;
                    issued  <= '0;
                    rcvd    <= '0;
                end
            end
        end
    end

endmodule
